tx_lane_striper: RTL
====================

# tx_lane_striper

Parametrised TX byte-striping stage between the TX data/ordered-set mux and the per-lane scramblers, replacing the fixed 16-lane lane-management block. It buffers full-width input words and distributes bytes across a runtime-selected number of active lanes (x1..xLANESNUMBER), at a per-generation PIPE width. It adds a ready/valid handshake with backpressure, optional lane reversal, and a synchronous flush.

## Interface
Parameters:
- LANESNUMBER, 16, physical lane count; power of two, 1..16.
- IN_BYTES, 64, bytes per input word; power of two, at least LANESNUMBER*MAXPIPEWIDTH/8.
- MAXPIPEWIDTH, 32, maximum per-lane PIPE width in bits: 8, 16 or 32.
- GEN1_PIPEWIDTH..GEN5_PIPEWIDTH, 8, per-generation PIPE width in bits: 8, 16 or 32, each at most MAXPIPEWIDTH.

Ports:
- pclk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- gen  in  3  current generation, 1..5; values 0, 6 and 7 are treated as 1.
- lane_code  in  3  active lane count = 2^lane_code; values above log2(LANESNUMBER) clamp to LANESNUMBER.
- lane_reverse  in  1  maps logical lane i to physical lane LANESNUMBER-1-i.
- flush  in  1  discards buffered bytes.
- in_data  in  8*IN_BYTES  input bytes; byte 0 is in bits [7:0] and is sent first.
- in_datak  in  IN_BYTES  per-byte K flag.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- lane_data  out  LANESNUMBER*MAXPIPEWIDTH  per-lane data; lane p occupies slice p.
- lane_datak  out  LANESNUMBER*MAXPIPEWIDTH/8  per-lane K flags.
- lane_valid  out  LANESNUMBER  per-lane valid.

## Operation
- Derived quantities:
  - PW = pipe width for the latched gen, in bytes (1, 2 or 4).
  - AL = latched active lane count.
  - OUT_BYTES = AL*PW bytes emitted per cycle. OUT_BYTES always divides IN_BYTES.
- Byte buffer:
  - Capacity DEPTH = 2*IN_BYTES bytes, FIFO order, with a byte count `count` in 0..DEPTH.
  - in_ready = (count <= DEPTH-IN_BYTES) and not flush. This is combinational from registered state.
  - Accept occurs when in_valid and in_ready are both high; all IN_BYTES bytes are appended.
  - Emit occurs when count >= OUT_BYTES; the oldest OUT_BYTES bytes are removed.
  - Accept and emit in the same cycle: count_next = count + IN_BYTES - OUT_BYTES.
  - count is always a multiple of OUT_BYTES. There are no partial groups.
- Striping: emitted byte k goes to logical lane k mod AL, slot k/AL. Slot s occupies bits [8s+7:8s] of the lane slice.
- Config latch:
  - gen, lane_code and lane_reverse are latched only on a cycle where count==0 and no accept occurs, or on flush.
  - Changes while the buffer is non-empty are deferred until it drains.
- flush: the next cycle has count=0, no emission, and a config re-latch. in_valid is ignored while flush is high.
- Unused bytes:
  - Inactive physical lanes: data=0, datak=0, valid=0.
  - Slots at or above PW on active lanes are driven 0.
- Reset values:
  - count=0.
  - Latched config = gen1, x1, no reversal.
  - All lane_data, lane_datak and lane_valid = 0; in_ready = 1 after reset deasserts.
- Reset mid-operation clears the buffer immediately and drops buffered bytes. No partial group is emitted.

## Timing
- Output registers are updated on the cycle an emit occurs.
- Minimum latency: a word accepted at edge t with an empty buffer and a stable config appears on the lanes after edge t+1.
- lane_valid is high for exactly one cycle per emitted group, on the active lanes only. All active lanes assert together.
- Throughput: IN_BYTES/OUT_BYTES output cycles per input word.
  - in_ready stays high under continuous input when OUT_BYTES == IN_BYTES.
  - Otherwise in_ready deasserts once count > DEPTH-IN_BYTES.
- Full: count == DEPTH forces in_ready=0. An emit in that cycle does not make in_ready high until the next cycle.
- Empty: count == 0 with no accept gives all lane_valid=0 on the next cycle.

## Test plan
- x16, gen1 (PW=1), IN_BYTES=64, one word with bytes 0x00..0x3F:
  - 4 output cycles.
  - Cycle c, lane i carries 0x(16c+i).
  - lane_valid=0xFFFF each cycle; in_ready never drops.
- x1, gen3 with GEN3_PIPEWIDTH=32, back-to-back words:
  - Emits 4 bytes per cycle.
  - in_ready falls after the 2nd accept and then toggles 1-in-16.
  - No byte is lost or reordered across 8 words.
- x4 with lane_reverse=1, gen1, bytes 0xA0..:
  - Byte 0xA0 appears on physical lane 15, 0xA1 on lane 14.
  - Lanes 0..11 valid=0, data=0.
- lane_code changed from 4 to 2 while count=64:
  - Striping stays x16 until drained.
  - The next word after the drain stripes x4.
- flush asserted with count=96 and in_valid=1:
  - Next cycle count=0, lane_valid=0, in_ready=1.
  - The word presented with flush is not stored.
- reset asserted asynchronously mid-emission:
  - Outputs go to 0 without waiting for a clock edge.
  - After release, the first new word is striped with gen1/x1 defaults.

Source files
------------

// File: rtl/tx_lane_striper.sv
// tx_lane_striper: buffers full-width TX words and stripes bytes across a runtime-selected set of lanes.
module tx_lane_striper #(
  parameter int LANESNUMBER    = 16,
  parameter int IN_BYTES       = 64,
  parameter int MAXPIPEWIDTH   = 32,
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 8,
  parameter int GEN3_PIPEWIDTH = 8,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic                                pclk,
  input  logic                                reset,
  input  logic [2:0]                          gen,
  input  logic [2:0]                          lane_code,
  input  logic                                lane_reverse,
  input  logic                                flush,
  input  logic [8*IN_BYTES-1:0]               in_data,
  input  logic [IN_BYTES-1:0]                 in_datak,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [LANESNUMBER*MAXPIPEWIDTH-1:0] lane_data,
  output logic [LANESNUMBER*MAXPIPEWIDTH/8-1:0] lane_datak,
  output logic [LANESNUMBER-1:0]              lane_valid
);
  localparam int DEPTH = 2*IN_BYTES;
  localparam int MPB = MAXPIPEWIDTH/8;
  localparam int LL = $clog2(LANESNUMBER);
  localparam int CW = $clog2(DEPTH+1) < 8 ? 8 : $clog2(DEPTH+1);
  logic [8:0] mem [DEPTH];
  logic [8:0] mem_n [DEPTH];
  logic [CW-1:0] count, count_n, ob, base;
  logic [2:0] al_log, pw;
  logic rev, accept, emit, relatch;
  logic [LANESNUMBER*MAXPIPEWIDTH-1:0] data_n;
  logic [LANESNUMBER*MAXPIPEWIDTH/8-1:0] datak_n;
  logic [LANESNUMBER-1:0] valid_n;
  assign ob = CW'(pw) << al_log;
  assign in_ready = count <= CW'(DEPTH-IN_BYTES) && !flush;
  assign accept = in_valid && in_ready;
  assign emit = !flush && count >= ob;
  assign relatch = flush || (count == '0 && !accept);
  assign base = emit ? count - ob : count;
  assign count_n = flush ? '0 : count + (accept ? CW'(IN_BYTES) : '0) - (emit ? ob : '0);
  // Each entry shifts down by the emitted group, then the new word lands right after the survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_n[i] = mem[i];
      if (emit && i + int'(ob) < DEPTH)
        mem_n[i] = mem[i + int'(ob)];
      if (accept && i >= int'(base) && i < int'(base) + IN_BYTES)
        mem_n[i] = {in_datak[i - int'(base)], in_data[8*(i - int'(base)) +: 8]};
    end
  end
  always_comb begin
    data_n = '0;
    datak_n = '0;
    valid_n = '0;
    for (int l = 0; l < LANESNUMBER; l++) begin
      int p;
      p = rev ? LANESNUMBER-1-l : l;
      if (emit && l < (1 << al_log)) begin
        valid_n[p] = 1'b1;
        for (int s = 0; s < MPB; s++)
          if (s < int'(pw)) begin
            data_n[p*MAXPIPEWIDTH + 8*s +: 8] = mem[s*(1 << al_log) + l][7:0];
            datak_n[p*MPB + s] = mem[s*(1 << al_log) + l][8];
          end
      end
    end
  end
  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      count <= '0;
      al_log <= '0;
      pw <= 3'd1;
      rev <= 1'b0;
      lane_data <= '0;
      lane_datak <= '0;
      lane_valid <= '0;
    end else begin
      count <= count_n;
      lane_data <= data_n;
      lane_datak <= datak_n;
      lane_valid <= valid_n;
      if (relatch) begin
        al_log <= lane_code > 3'(LL) ? 3'(LL) : lane_code;
        pw <= gen == 3'd2 ? 3'(GEN2_PIPEWIDTH/8) :
              gen == 3'd3 ? 3'(GEN3_PIPEWIDTH/8) :
              gen == 3'd4 ? 3'(GEN4_PIPEWIDTH/8) :
              gen == 3'd5 ? 3'(GEN5_PIPEWIDTH/8) : 3'(GEN1_PIPEWIDTH/8);
        rev <= lane_reverse;
      end
    end
  always_ff @(posedge pclk)
    mem <= mem_n;
endmodule
